// File: rtl/nuc_dsp_ml_pkg.sv
// Shared widths, latency and arithmetic helpers for the NUC correction engine.
package nuc_pkg;

  localparam int unsigned DEF_LANES      = 2;
  localparam int unsigned DEF_DIN_WIDTH  = 14;
  localparam int unsigned DEF_GAIN_WIDTH = 15;
  localparam int unsigned DEF_GAIN_FRAC  = 14;
  localparam int unsigned DEF_OFST_WIDTH = 16;
  localparam int unsigned NUC_LATENCY    = 4;

  typedef enum logic {
    BAD_ZERO    = 1'b0,
    BAD_REPLACE = 1'b1
  } bad_mode_e;

  function automatic longint unsigned unity_gain(input int unsigned frac);
    return 64'd1 << frac;
  endfunction

  // Clamp a signed value into [0, 2^w-1]; caller narrows the result to w bits.
  function automatic logic [63:0] sat_u(input logic signed [63:0] r, input int unsigned w);
    logic signed [63:0] maxv;
    maxv = (64'sd1 <<< w) - 64'sd1;
    if (r < 64'sd0)
      return '0;
    else if (r > maxv)
      return maxv;
    else
      return r;
  endfunction

endpackage

// File: rtl/nuc_dsp_ml_lane.sv
// One lane of the NUC datapath: S1 input regs, S2 multiply, S3 offset add, then saturation.
module nuc_lane
  import nuc_pkg::*;
#(
  parameter int unsigned DIN_WIDTH  = DEF_DIN_WIDTH,
  parameter int unsigned GAIN_WIDTH = DEF_GAIN_WIDTH,
  parameter int unsigned GAIN_FRAC  = DEF_GAIN_FRAC,
  parameter int unsigned OFST_WIDTH = DEF_OFST_WIDTH
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  cen,
  input  logic [DIN_WIDTH-1:0]  din_i,
  input  logic [GAIN_WIDTH-1:0] gain_i,
  input  logic [OFST_WIDTH-1:0] ofst_i,
  output logic [DIN_WIDTH-1:0]  sat_o
);

  localparam int unsigned PRODW = DIN_WIDTH + GAIN_WIDTH;
  localparam int unsigned OFSW  = OFST_WIDTH + GAIN_FRAC;
  // Two guard bits: one for the sign, one for the carry of the add.
  localparam int unsigned PW    = ((PRODW > OFSW) ? PRODW : OFSW) + 2;

  logic [DIN_WIDTH-1:0]  din_q;
  logic [GAIN_WIDTH-1:0] gain_q;
  logic [OFST_WIDTH-1:0] ofst_q, ofs2_q;
  logic [PRODW-1:0]      prod_q, prod_d;
  logic signed [PW-1:0]  p_q, p_d, r;

  always_comb begin
    prod_d = PRODW'(din_q) * PRODW'(gain_q);
    p_d    = $signed({{(PW-PRODW){1'b0}}, prod_q})
           + $signed({{(PW-OFSW){ofs2_q[OFST_WIDTH-1]}}, ofs2_q, {GAIN_FRAC{1'b0}}});
    r      = p_q >>> GAIN_FRAC;
    sat_o  = DIN_WIDTH'(sat_u(64'(r), DIN_WIDTH));
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      din_q  <= '0;
      gain_q <= '0;
      ofst_q <= '0;
      prod_q <= '0;
      ofs2_q <= '0;
      p_q    <= '0;
    end else if (cen) begin
      din_q  <= din_i;
      gain_q <= gain_i;
      ofst_q <= ofst_i;
      prod_q <= prod_d;
      ofs2_q <= ofst_q;
      p_q    <= p_d;
    end
  end

endmodule

// File: rtl/nuc_dsp_ml_pipe.sv
// Plain delay line with clock enable and synchronous clear, used for side-band data.
module nuc_pipe #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned PIPE_STAGES = 3
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             cen,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [PIPE_STAGES];

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int unsigned i = 0; i < PIPE_STAGES; i++) stage_q[i] <= '0;
    end else if (cen) begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < PIPE_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[PIPE_STAGES-1];

endmodule

// File: rtl/nuc_dsp_ml.sv
// Multi-lane NUC engine: per-lane gain/offset correction, bad-pixel handling, fixed 4-beat latency.
module nuc_dsp_ml
  import nuc_pkg::*;
#(
  parameter int unsigned LANES      = DEF_LANES,
  parameter int unsigned DIN_WIDTH  = DEF_DIN_WIDTH,
  parameter int unsigned GAIN_WIDTH = DEF_GAIN_WIDTH,
  parameter int unsigned GAIN_FRAC  = DEF_GAIN_FRAC,
  parameter int unsigned OFST_WIDTH = DEF_OFST_WIDTH
) (
  input  logic                            clk,
  input  logic                            srst,
  input  logic                            cen,
  input  logic                            bypass,
  input  logic                            bad_mode,
  input  logic                            s_valid,
  input  logic                            s_last,
  input  logic [LANES*DIN_WIDTH-1:0]      din,
  input  logic [LANES*(GAIN_WIDTH+1)-1:0] gain,
  input  logic [LANES*OFST_WIDTH-1:0]     ofst,
  output logic                            m_valid,
  output logic                            m_last,
  output logic [LANES*DIN_WIDTH-1:0]      dout,
  output logic [LANES-1:0]                dout_good
);

  localparam int unsigned GW1 = GAIN_WIDTH + 1;
  localparam int unsigned SBW = 4 + LANES + LANES*DIN_WIDTH;

  logic [LANES-1:0]           good_in;
  logic [SBW-1:0]             sb_d, sb_q;
  logic                       v3, last3, byp3, bm3;
  logic [LANES-1:0]           good3;
  logic [LANES*DIN_WIDTH-1:0] raw3;
  logic [DIN_WIDTH-1:0]       corr [LANES];

  logic                       m_valid_q, m_last_q;
  logic [LANES*DIN_WIDTH-1:0] dout_q, dout_d;
  logic [LANES-1:0]           good_q;
  logic [DIN_WIDTH-1:0]       hist_q, hist_d, carry;
  logic                       any_good;

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) good_in[l] = gain[l*GW1 + GAIN_WIDTH];
  end

  // Modes travel with the beat so a mid-stream change never splits one.
  assign sb_d = {s_valid, s_valid & s_last, bypass, bad_mode, good_in, din};

  nuc_pipe #(
    .WIDTH       (SBW),
    .PIPE_STAGES (NUC_LATENCY - 1)
  ) u_sideband (
    .clk  (clk),
    .srst (srst),
    .cen  (cen),
    .d_i  (sb_d),
    .q_o  (sb_q)
  );

  assign {v3, last3, byp3, bm3, good3, raw3} = sb_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    nuc_lane #(
      .DIN_WIDTH  (DIN_WIDTH),
      .GAIN_WIDTH (GAIN_WIDTH),
      .GAIN_FRAC  (GAIN_FRAC),
      .OFST_WIDTH (OFST_WIDTH)
    ) u_lane (
      .clk    (clk),
      .srst   (srst),
      .cen    (cen),
      .din_i  (din[g*DIN_WIDTH +: DIN_WIDTH]),
      .gain_i (gain[g*GW1 +: GAIN_WIDTH]),
      .ofst_i (ofst[g*OFST_WIDTH +: OFST_WIDTH]),
      .sat_o  (corr[g])
    );
  end

  // carry walks left to right: history first, then each good lane's result.
  always_comb begin
    carry    = hist_q;
    any_good = 1'b0;
    dout_d   = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (byp3) begin
        dout_d[l*DIN_WIDTH +: DIN_WIDTH] = raw3[l*DIN_WIDTH +: DIN_WIDTH];
      end else if (good3[l]) begin
        dout_d[l*DIN_WIDTH +: DIN_WIDTH] = corr[l];
        carry    = corr[l];
        any_good = 1'b1;
      end else if (bad_mode_e'(bm3) == BAD_REPLACE) begin
        dout_d[l*DIN_WIDTH +: DIN_WIDTH] = carry;
      end
    end
    hist_d = hist_q;
    if (v3) begin
      if (last3)
        hist_d = '0;
      else if (!byp3 && any_good)
        hist_d = carry;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      dout_q    <= '0;
      good_q    <= '0;
      hist_q    <= '0;
    end else if (cen) begin
      m_valid_q <= v3;
      m_last_q  <= last3;
      dout_q    <= dout_d;
      good_q    <= good3;
      hist_q    <= hist_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign dout      = dout_q;
  assign dout_good = good_q;

endmodule

// File: tb/tb_nuc_dsp_ml.sv
// Self-checking bench for nuc_dsp_ml: directed beats plus randomized stream against a beat-level model.
module tb_nuc_dsp_ml;
  import nuc_pkg::*;

  localparam int L  = 2;
  localparam int DW = 14;
  localparam int GW = 15;
  localparam int GF = 14;
  localparam int OW = 16;
  localparam int MAXV = (1 << DW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic srst, cen, bypass, bad_mode, s_valid, s_last;
  logic [L*DW-1:0]     din;
  logic [L*(GW+1)-1:0] gain;
  logic [L*OW-1:0]     ofst;
  logic                m_valid, m_last;
  logic [L*DW-1:0]     dout;
  logic [L-1:0]        dout_good;

  nuc_dsp_ml #(
    .LANES      (L),
    .DIN_WIDTH  (DW),
    .GAIN_WIDTH (GW),
    .GAIN_FRAC  (GF),
    .OFST_WIDTH (OW)
  ) dut (
    .clk       (clk),
    .srst      (srst),
    .cen       (cen),
    .bypass    (bypass),
    .bad_mode  (bad_mode),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .din       (din),
    .gain      (gain),
    .ofst      (ofst),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .dout      (dout),
    .dout_good (dout_good)
  );

  typedef struct {
    bit v, last, byp, bm;
    int d[L];
    int g[L];
    bit gf[L];
    int o[L];
  } beat_t;

  typedef struct {
    int d[L];
    int g;
  } obs_t;

  beat_t inflight[$];
  beat_t cur, outb;
  obs_t  got[$];
  obs_t  ob;
  int    hist = 0;
  bit    exp_valid = 0, exp_last = 0;
  int    exp_dout[L];
  bit    exp_good[L];
  bit    cen_edge = 0;
  int    n_in = 0, n_exp_out = 0, n_dut_out = 0;
  int    n_cmp = 0, n_bad = 0;
  int    unity;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  function automatic int correct(input int d, input int g, input int o);
    longint p, r;
    p = longint'(d) * longint'(g) + longint'(o) * (longint'(1) << GF);
    r = p >>> GF;
    if (r < 0) return 0;
    if (r > MAXV) return MAXV;
    return int'(r);
  endfunction

  task automatic model_emit(input beat_t b);
    int  c[L];
    int  hi;
    bit  found;
    exp_valid = b.v;
    exp_last  = b.last;
    if (b.v) begin
      n_exp_out++;
      for (int l = 0; l < L; l++) c[l] = correct(b.d[l], b.g[l], b.o[l]);
      for (int l = 0; l < L; l++) begin
        exp_good[l] = b.gf[l];
        if (b.byp) exp_dout[l] = b.d[l];
        else if (b.gf[l]) exp_dout[l] = c[l];
        else if (!b.bm) exp_dout[l] = 0;
        else begin
          found = 0;
          exp_dout[l] = hist;
          for (int j = l - 1; j >= 0; j--)
            if (b.gf[j] && !found) begin
              exp_dout[l] = c[j];
              found = 1;
            end
        end
      end
      hi = -1;
      for (int l = 0; l < L; l++) if (b.gf[l]) hi = l;
      if (b.last) hist = 0;
      else if (!b.byp && hi >= 0) hist = c[hi];
    end
  endtask

  always @(posedge clk) begin
    cen_edge = 0;
    if (srst) begin
      inflight.delete();
      hist      = 0;
      exp_valid = 0;
      exp_last  = 0;
      for (int l = 0; l < L; l++) begin
        exp_dout[l] = 0;
        exp_good[l] = 0;
      end
    end else if (cen) begin
      cen_edge = 1;
      cur.v    = s_valid;
      cur.last = s_valid && s_last;
      cur.byp  = bypass;
      cur.bm   = bad_mode;
      for (int l = 0; l < L; l++) begin
        cur.d[l]  = int'(din[l*DW +: DW]);
        cur.g[l]  = int'(gain[l*(GW+1) +: GW]);
        cur.gf[l] = gain[l*(GW+1) + GW];
        cur.o[l]  = int'($signed(ofst[l*OW +: OW]));
      end
      if (s_valid) n_in++;
      inflight.push_back(cur);
      if (inflight.size() == NUC_LATENCY) begin
        outb = inflight.pop_front();
        model_emit(outb);
      end else begin
        exp_valid = 0;
        exp_last  = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("m_valid", 32'(m_valid), 32'(exp_valid));
      chk("m_last", 32'(m_last), 32'(exp_last));
      if (exp_valid) begin
        for (int l = 0; l < L; l++) begin
          chk($sformatf("dout[%0d]", l), 32'(dout[l*DW +: DW]), 32'(exp_dout[l]));
          chk($sformatf("dout_good[%0d]", l), 32'(dout_good[l]), 32'(exp_good[l]));
        end
      end
      if (cen_edge && m_valid) begin
        n_dut_out++;
        for (int l = 0; l < L; l++) ob.d[l] = int'(dout[l*DW +: DW]);
        ob.g = int'(dout_good);
        got.push_back(ob);
      end
    end
  end

  task automatic send(input int d0, input int g0, input bit f0, input int o0,
                      input int d1, input int g1, input bit f1, input int o1,
                      input bit last, input bit byp, input bit bm);
    @(negedge clk);
    s_valid  = 1'b1;
    s_last   = last;
    bypass   = byp;
    bad_mode = bm;
    din      = {DW'(d1), DW'(d0)};
    gain     = {f1, GW'(g1), f0, GW'(g0)};
    ofst     = {OW'(o1), OW'(o0)};
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cen     = 1'b1;
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_tab[8][2];
    int n_before, lat;
    exp_tab = '{'{1000, 2000}, '{1400, 1400}, '{16383, 0}, '{500, 600},
                '{600, 600}, '{0, 700}, '{500, 600}, '{0, 0}};
    unity = int'(unity_gain(GF));
    srst = 1; cen = 1; bypass = 0; bad_mode = 0; s_valid = 0; s_last = 0;
    din = '0; gain = '0; ofst = '0;
    repeat (3) @(negedge clk);
    srst = 0;

    // Directed beats: unity, scaling, saturation, replacement, zeroing.
    send(1000, unity, 1, 0,     2000, unity, 1, 0,    0, 0, 0);
    send(1000, 24576, 1, -100,  1000, 24576, 1, -100, 0, 0, 0);
    send(16383, 32767, 1, 0,    100, unity, 1, -200,  0, 0, 0);
    send(500, unity, 1, 0,      600, unity, 1, 0,     0, 0, 1);
    send(123, 9999, 0, 0,       456, 9999, 0, 0,      1, 0, 1);
    send(321, 9999, 0, 0,       700, unity, 1, 0,     0, 0, 1);
    send(500, unity, 1, 0,      600, unity, 1, 0,     0, 0, 0);
    send(123, 9999, 0, 0,       456, 9999, 0, 0,      1, 0, 0);
    idle(8);
    chk("directed_count", 32'(got.size()), 32'd8);
    if (got.size() >= 8) begin
      for (int i = 0; i < 8; i++)
        for (int l = 0; l < L; l++)
          chk($sformatf("directed_beat%0d_lane%0d", i, l), 32'(got[i].d[l]), 32'(exp_tab[i][l]));
      chk("directed_good0", 32'(got[0].g), 32'd3);
      chk("directed_goodB", 32'(got[4].g), 32'd0);
    end

    // Randomized stream with gaps, stalls, mode changes and line ends.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (i >= 200 && i < 203) cen = 1'b0;
      else cen = ($urandom_range(0, 7) != 0);
      s_valid  = ($urandom_range(0, 9) < 7);
      s_last   = ($urandom_range(0, 9) == 0);
      bypass   = ($urandom_range(0, 4) == 0);
      bad_mode = $urandom_range(0, 1);
      for (int l = 0; l < L; l++) begin
        din[l*DW +: DW]       = DW'($urandom_range(0, MAXV));
        gain[l*(GW+1) +: GW]  = ($urandom_range(0, 1) != 0) ? GW'($urandom_range(12000, 20000))
                                                             : GW'($urandom_range(0, 32767));
        gain[l*(GW+1) + GW]   = ($urandom_range(0, 3) != 0);
        ofst[l*OW +: OW]      = OW'($urandom_range(0, 65535));
      end
    end
    idle(10);
    chk("beat_count", 32'(n_dut_out), 32'(n_in));

    // Reset with three beats in flight.
    send(10, unity, 1, 5, 20, unity, 1, 5, 0, 0, 0);
    send(11, unity, 1, 5, 21, unity, 1, 5, 0, 0, 0);
    send(12, unity, 1, 5, 22, unity, 1, 5, 1, 0, 0);
    @(negedge clk);
    s_valid = 0;
    s_last  = 0;
    srst    = 1;
    @(posedge clk);
    #2;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_dout_good", 32'(dout_good), 32'd0);
    @(negedge clk);
    srst = 0;
    n_before = n_dut_out;
    idle(6);
    chk("rst_no_emerge", 32'(n_dut_out), 32'(n_before));

    send(77, unity, 1, 3, 88, unity, 1, -8, 0, 0, 0);
    @(posedge clk);
    #2;
    lat = 1;
    while (!m_valid && lat < 12) begin
      @(posedge clk);
      #2;
      lat++;
    end
    chk("post_rst_latency", 32'(lat), 32'(NUC_LATENCY));
    chk("post_rst_lane0", 32'(dout[0 +: DW]), 32'd80);
    chk("post_rst_lane1", 32'(dout[DW +: DW]), 32'd80);
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
